// File: rtl/dispatch_ctrl.sv
// In-order dispatch controller: 2-entry decode FIFO, one-hot FU steering, ROB tag allocation, global flush.
// Define DISPATCH_PERF_EN to add the saturating stall counters perf_stall_rs / perf_stall_rob.
module dispatch_ctrl #(
  parameter  int unsigned PAYLOAD_W = 64,
  parameter  int unsigned ROB_DEPTH = 16,
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [2:0]           dec_fu_type,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic                 lsq_valid,
  input  logic                 lsq_ready,
  output logic                 bra_valid,
  input  logic                 bra_ready,
  output logic [PAYLOAD_W-1:0] disp_payload,
  output logic [TAG_W-1:0]     disp_tag,
  input  logic                 rob_commit,
  input  logic                 flush,
  output logic                 illegal_pulse,
  output logic [TAG_W:0]       rob_free_cnt,
  output logic                 commit_err
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_stall_rs,
  output logic [31:0]          perf_stall_rob
`endif
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [2:0]             r_fu [2];
  logic [PAYLOAD_W-1:0]   r_pl [2];
  logic                   r_rd_ptr;
  logic                   r_wr_ptr;
  logic [1:0]             r_count;
  logic [TAG_W-1:0]       r_alloc;
  logic [TAG_W:0]         r_free;
  logic                   r_commit_err;

  logic                   w_head_vld;
  logic [2:0]             w_head_fu;
  logic                   w_legal;
  logic                   w_active;
  logic                   w_rob_space;
  logic                   w_issue;
  logic                   w_fire;
  logic                   w_illegal;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_commit_err_cond;
  logic                   w_commit_inc;

  assign w_head_vld  = (r_count != 2'd0);
  assign w_head_fu   = r_fu[r_rd_ptr];
  assign w_legal     = (w_head_fu == 3'b001) | (w_head_fu == 3'b010) | (w_head_fu == 3'b100);
  assign w_active    = (r_state != ST_FLUSH);
  assign w_rob_space = (r_free != '0);

  // Valids depend only on head, ROB space and state, so they hold until fire or flush.
  assign w_issue   = w_head_vld & w_legal & w_rob_space & w_active;
  assign alu_valid = w_issue & w_head_fu[0];
  assign lsq_valid = w_issue & w_head_fu[1];
  assign bra_valid = w_issue & w_head_fu[2];

  assign w_fire    = (alu_valid & alu_ready) | (lsq_valid & lsq_ready) | (bra_valid & bra_ready);
  assign w_illegal = w_head_vld & ~w_legal & w_active;
  assign w_pop     = w_fire | w_illegal;

  assign dec_ready = (r_count != 2'd2) & (r_state == ST_RUN);
  assign w_push    = dec_valid & dec_ready;

  assign w_commit_err_cond = rob_commit & (r_free == FULL_CNT);
  assign w_commit_inc      = rob_commit & ~w_commit_err_cond;

  assign disp_payload  = r_pl[r_rd_ptr];
  assign disp_tag      = r_alloc;
  assign illegal_pulse = w_illegal;
  assign rob_free_cnt  = r_free;
  assign commit_err    = r_commit_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN:   if (w_head_vld & w_legal & ~w_fire) w_state_nxt = ST_STALL;
        ST_STALL: if (w_fire | ~w_head_vld | w_illegal) w_state_nxt = ST_RUN;
        ST_FLUSH: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_fu[i] <= '0;
        r_pl[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fu[r_wr_ptr] <= dec_fu_type;
        r_pl[r_wr_ptr] <= dec_payload;
        r_wr_ptr       <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ROB_DEPTH is a power of two, so the tag pointer wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc <= '0;
      r_free  <= FULL_CNT;
    end else if (flush) begin
      r_alloc <= '0;
      r_free  <= FULL_CNT;
    end else begin
      if (w_fire) begin
        r_alloc <= r_alloc + 1'b1;
      end
      case ({w_fire, w_commit_inc})
        2'b10:   r_free <= r_free - 1'b1;
        2'b01:   r_free <= r_free + 1'b1;
        default: r_free <= r_free;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_err <= 1'b0;
    end else if (w_commit_err_cond) begin
      r_commit_err <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] r_perf_rs;
  logic [31:0] r_perf_rob;
  logic        w_cnt_rs;
  logic        w_cnt_rob;

  assign w_cnt_rs  = w_issue & ~w_fire;
  assign w_cnt_rob = w_head_vld & w_legal & ~w_rob_space & w_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_rs  <= '0;
      r_perf_rob <= '0;
    end else begin
      if (w_cnt_rs && (r_perf_rs != '1)) begin
        r_perf_rs <= r_perf_rs + 32'd1;
      end
      if (w_cnt_rob && (r_perf_rob != '1)) begin
        r_perf_rob <= r_perf_rob + 32'd1;
      end
    end
  end

  assign perf_stall_rs  = r_perf_rs;
  assign perf_stall_rob = r_perf_rob;
`endif

endmodule
